// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_MEM} gnt_t;
    localparam logic [63:0] BE_ALL = '1;
endpackage

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: grant and conflict counters, built only with MEM_ARBITER_PERF_EN.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  gnt_t        gnt,
    input  logic        conflict,
    output logic [31:0] if_grants,
    output logic [31:0] mem_grants,
    output logic [31:0] conflicts
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_grants  <= '0;
            mem_grants <= '0;
            conflicts  <= '0;
        end else begin
            if_grants  <= if_grants + 32'(gnt == GNT_IF);
            mem_grants <= mem_grants + 32'(gnt == GNT_MEM);
            conflicts  <= conflicts + 32'(conflict);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction at a time.
// Optional MEM_ARBITER_PERF_EN adds grant/conflict counter outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_if_req,
    input  logic [ADDR_W-1:0]   in_if_addr,
    input  logic                in_if_flush,
    output logic                out_if_valid,
    output logic [DATA_W-1:0]   out_if_rdata,
    output logic                out_if_stall,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [ADDR_W-1:0]   in_mem_addr,
    input  logic [DATA_W-1:0]   in_mem_wdata,
    input  logic [DATA_W/8-1:0] in_mem_be,
    output logic                out_mem_valid,
    output logic [DATA_W-1:0]   out_mem_rdata,
    output logic                out_mem_stall,
    output logic                out_ram_req,
    output logic                out_ram_we,
    output logic [ADDR_W-1:0]   out_ram_addr,
    output logic [DATA_W-1:0]   out_ram_wdata,
    output logic [DATA_W/8-1:0] out_ram_be,
    input  logic                in_ram_ack,
    input  logic [DATA_W-1:0]   in_ram_rdata
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]         out_perf_if_grants,
    output logic [31:0]         out_perf_mem_grants,
    output logic [31:0]         out_perf_conflicts
`endif
);
    state_t state;
    gnt_t   gnt;
    logic   mem_req;
    logic   squash;

    // MEM wins a tie: it belongs to the older instruction
    assign mem_req = in_mem_read | in_mem_write;
    assign gnt = state != IDLE ? GNT_NONE :
                 mem_req ? GNT_MEM :
                 (in_if_req && !in_if_flush) ? GNT_IF : GNT_NONE;

    assign out_if_valid  = state == IF_BUSY && in_ram_ack && !(squash || in_if_flush);
    assign out_mem_valid = state == MEM_BUSY && in_ram_ack;
    assign out_if_rdata  = out_if_valid ? in_ram_rdata : '0;
    assign out_mem_rdata = (out_mem_valid && !out_ram_we) ? in_ram_rdata : '0;
    assign out_if_stall  = in_if_req && !out_if_valid;
    assign out_mem_stall = mem_req && !out_mem_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            squash        <= 1'b0;
            out_ram_req   <= 1'b0;
            out_ram_we    <= 1'b0;
            out_ram_addr  <= '0;
            out_ram_wdata <= '0;
            out_ram_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt == GNT_MEM) begin
                        state         <= MEM_BUSY;
                        out_ram_req   <= 1'b1;
                        out_ram_we    <= in_mem_write;
                        out_ram_addr  <= in_mem_addr;
                        out_ram_wdata <= in_mem_wdata;
                        out_ram_be    <= in_mem_be;
                    end else if (gnt == GNT_IF) begin
                        state         <= IF_BUSY;
                        out_ram_req   <= 1'b1;
                        out_ram_we    <= 1'b0;
                        out_ram_addr  <= in_if_addr;
                        out_ram_wdata <= '0;
                        out_ram_be    <= BE_ALL[DATA_W/8-1:0];
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    // a squashed fetch still runs to its ack; only the response is dropped
                    if (in_ram_ack) begin
                        state       <= IDLE;
                        out_ram_req <= 1'b0;
                        squash      <= 1'b0;
                    end else if (state == IF_BUSY && in_if_flush) begin
                        squash <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    mem_arb_perf u_perf (
        .clk        (clk),
        .reset_n    (reset_n),
        .gnt        (gnt),
        .conflict   (state == IDLE && mem_req && in_if_req),
        .if_grants  (out_perf_if_grants),
        .mem_grants (out_perf_mem_grants),
        .conflicts  (out_perf_conflicts)
    );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_if_req, in_if_flush, in_mem_read, in_mem_write, in_ram_ack;
    logic [31:0] in_if_addr, in_mem_addr, in_mem_wdata, in_ram_rdata;
    logic [3:0]  in_mem_be;
    logic        out_if_valid, out_if_stall, out_mem_valid, out_mem_stall;
    logic        out_ram_req, out_ram_we;
    logic [31:0] out_if_rdata, out_mem_rdata, out_ram_addr, out_ram_wdata;
    logic [3:0]  out_ram_be;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_if_req(in_if_req), .in_if_addr(in_if_addr), .in_if_flush(in_if_flush),
        .out_if_valid(out_if_valid), .out_if_rdata(out_if_rdata), .out_if_stall(out_if_stall),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_addr(in_mem_addr),
        .in_mem_wdata(in_mem_wdata), .in_mem_be(in_mem_be),
        .out_mem_valid(out_mem_valid), .out_mem_rdata(out_mem_rdata), .out_mem_stall(out_mem_stall),
        .out_ram_req(out_ram_req), .out_ram_we(out_ram_we), .out_ram_addr(out_ram_addr),
        .out_ram_wdata(out_ram_wdata), .out_ram_be(out_ram_be),
        .in_ram_ack(in_ram_ack), .in_ram_rdata(in_ram_rdata)
`ifdef MEM_ARBITER_PERF_EN
        , .out_perf_if_grants(out_perf_if_grants), .out_perf_mem_grants(out_perf_mem_grants),
        .out_perf_conflicts(out_perf_conflicts)
`endif
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic idle_in;
        in_if_req = 0; in_if_addr = 0; in_if_flush = 0;
        in_mem_read = 0; in_mem_write = 0; in_mem_addr = 0; in_mem_wdata = 0; in_mem_be = 0;
        in_ram_ack = 0; in_ram_rdata = 0;
    endtask

    task automatic do_reset;
        reset_n = 0;
        idle_in();
        cyc(); cyc();
        reset_n = 1;
    endtask

    task automatic test_reset;
        idle_in();
        in_if_req = 1; in_ram_ack = 1; in_ram_rdata = 32'hFFFF_FFFF;
        cyc(); cyc(); smp();
        checks++; if (out_ram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", out_ram_req); end
        checks++; if ({out_ram_we, out_ram_addr, out_ram_wdata, out_ram_be} !== 69'd0) begin errors++; $display("FAIL reset_fields got %0h/%0h/%0h/%0h want 0", out_ram_we, out_ram_addr, out_ram_wdata, out_ram_be); end
        checks++; if ({out_if_valid, out_mem_valid, out_if_stall, out_mem_stall} !== 4'b0010) begin errors++; $display("FAIL reset_outs got %b want 0010", {out_if_valid, out_mem_valid, out_if_stall, out_mem_stall}); end
        checks++; if (out_if_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %0h want 0", out_if_rdata); end
`ifdef MEM_ARBITER_PERF_EN
        checks++; if ({out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts} !== 96'd0) begin errors++; $display("FAIL reset_perf got %0h %0h %0h want 0", out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts); end
`endif
        idle_in();
        cyc();
        reset_n = 1;
    endtask

    task automatic test_fetch;
        cyc(); in_if_req = 1; in_if_addr = 32'h100; smp();
        checks++; if ({out_ram_req, out_if_stall} !== 2'b01) begin errors++; $display("FAIL fetch_c0 got req/stall %b want 01", {out_ram_req, out_if_stall}); end
        cyc(); smp();
        checks++; if ({out_ram_req, out_ram_we, out_ram_be, out_if_stall, out_if_valid} !== 8'b10_1111_10) begin errors++; $display("FAIL fetch_c1 got %b want 10111110", {out_ram_req, out_ram_we, out_ram_be, out_if_stall, out_if_valid}); end
        checks++; if (out_ram_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr got %0h want 100", out_ram_addr); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'h0050_0093; smp();
        checks++; if ({out_if_valid, out_if_stall} !== 2'b10) begin errors++; $display("FAIL fetch_valid got %b want 10", {out_if_valid, out_if_stall}); end
        checks++; if (out_if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata got %0h want 00500093", out_if_rdata); end
        cyc(); idle_in(); smp();
        checks++; if (out_ram_req !== 1'b0) begin errors++; $display("FAIL fetch_done got req %0b want 0", out_ram_req); end
    endtask

    task automatic test_collision;
        do_reset();
        cyc(); in_if_req = 1; in_if_addr = 32'h104; in_mem_read = 1; in_mem_addr = 32'h2000; smp();
        checks++; if ({out_ram_req, out_if_stall, out_mem_stall} !== 3'b011) begin errors++; $display("FAIL coll_c0 got %b want 011", {out_ram_req, out_if_stall, out_mem_stall}); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'hCAFE_0001; smp();
        checks++; if ({out_ram_req, out_ram_we, out_ram_addr} !== {2'b10, 32'h2000}) begin errors++; $display("FAIL coll_first got req/we/addr %0b/%0b/%0h want 1/0/2000", out_ram_req, out_ram_we, out_ram_addr); end
        checks++; if ({out_mem_valid, out_mem_stall, out_if_valid, out_if_stall} !== 4'b1001) begin errors++; $display("FAIL coll_flags got %b want 1001", {out_mem_valid, out_mem_stall, out_if_valid, out_if_stall}); end
        checks++; if (out_mem_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL coll_rdata got %0h want cafe0001", out_mem_rdata); end
        cyc(); in_mem_read = 0; in_ram_ack = 0; smp();
        checks++; if ({out_ram_req, out_if_stall} !== 2'b01) begin errors++; $display("FAIL coll_gap got %b want 01", {out_ram_req, out_if_stall}); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'h13; smp();
        checks++; if ({out_ram_req, out_ram_addr, out_if_valid, out_if_rdata} !== {1'b1, 32'h104, 1'b1, 32'h13}) begin errors++; $display("FAIL coll_fetch got req %0b addr %0h valid %0b rdata %0h want 1 104 1 13", out_ram_req, out_ram_addr, out_if_valid, out_if_rdata); end
        cyc(); idle_in();
`ifdef MEM_ARBITER_PERF_EN
        checks++; if ({out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts} !== {32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL coll_perf got %0d %0d %0d want 1 1 1", out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts); end
`endif
    endtask

    task automatic test_store;
        cyc(); in_mem_write = 1; in_mem_addr = 32'h2004; in_mem_wdata = 32'hDEAD_BEEF; in_mem_be = 4'b0011; smp();
        checks++; if ({out_ram_req, out_mem_stall} !== 2'b01) begin errors++; $display("FAIL store_c0 got %b want 01", {out_ram_req, out_mem_stall}); end
        cyc(); smp();
        checks++; if ({out_ram_req, out_ram_we, out_ram_be, out_ram_addr, out_ram_wdata} !== {2'b11, 4'b0011, 32'h2004, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_bus got req %0b we %0b be %b addr %0h wdata %0h want 1 1 0011 2004 deadbeef", out_ram_req, out_ram_we, out_ram_be, out_ram_addr, out_ram_wdata); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'h5555_5555; smp();
        checks++; if ({out_mem_valid, out_mem_stall, out_mem_rdata} !== {2'b10, 32'd0}) begin errors++; $display("FAIL store_ack got valid %0b stall %0b rdata %0h want 1 0 0", out_mem_valid, out_mem_stall, out_mem_rdata); end
        cyc(); idle_in();
    endtask

    task automatic test_flush;
        cyc(); in_if_req = 1; in_if_addr = 32'h108; smp();
        cyc(); in_if_flush = 1; smp();
        checks++; if ({out_ram_req, out_ram_addr, out_if_valid} !== {1'b1, 32'h108, 1'b0}) begin errors++; $display("FAIL flush_busy got req %0b addr %0h valid %0b want 1 108 0", out_ram_req, out_ram_addr, out_if_valid); end
        cyc(); in_if_flush = 0; in_if_req = 0; smp();
        checks++; if (out_ram_req !== 1'b1) begin errors++; $display("FAIL flush_hold got req %0b want 1", out_ram_req); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'h1234_5678; smp();
        checks++; if ({out_if_valid, out_if_rdata} !== 33'd0) begin errors++; $display("FAIL flush_squash got valid %0b rdata %0h want 0 0", out_if_valid, out_if_rdata); end
        cyc(); in_ram_ack = 0; smp();
        checks++; if (out_ram_req !== 1'b0) begin errors++; $display("FAIL flush_idle got req %0b want 0", out_ram_req); end
        cyc(); in_if_req = 1; in_if_addr = 32'h10C; in_if_flush = 1; smp();
        cyc(); in_if_flush = 0; smp();
        checks++; if (out_ram_req !== 1'b0) begin errors++; $display("FAIL flush_block got req %0b want 0", out_ram_req); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'hA5; smp();
        checks++; if ({out_ram_addr, out_if_valid, out_if_rdata} !== {32'h10C, 1'b1, 32'hA5}) begin errors++; $display("FAIL flush_regrant got addr %0h valid %0b rdata %0h want 10c 1 a5", out_ram_addr, out_if_valid, out_if_rdata); end
        cyc(); idle_in();
    endtask

    task automatic test_reset_mid;
        cyc(); in_mem_write = 1; in_mem_addr = 32'h2008; in_mem_wdata = 1; in_mem_be = 4'hF; in_if_req = 1; in_if_addr = 32'h110;
        cyc(); smp();
        checks++; if ({out_ram_req, out_ram_we} !== 2'b11) begin errors++; $display("FAIL rmid_busy got %b want 11", {out_ram_req, out_ram_we}); end
        #3 reset_n = 0; in_mem_write = 0;
        #1;
        checks++; if ({out_ram_req, out_ram_we, out_ram_addr} !== 34'd0) begin errors++; $display("FAIL rmid_async got req %0b we %0b addr %0h want 0 0 0", out_ram_req, out_ram_we, out_ram_addr); end
        cyc(); #2 reset_n = 1; smp();
        checks++; if ({out_ram_req, out_if_stall} !== 2'b01) begin errors++; $display("FAIL rmid_release got %b want 01", {out_ram_req, out_if_stall}); end
        cyc(); in_ram_ack = 1; in_ram_rdata = 32'h77; smp();
        checks++; if ({out_ram_req, out_ram_we, out_ram_be, out_ram_addr, out_if_valid} !== {2'b10, 4'hF, 32'h110, 1'b1}) begin errors++; $display("FAIL rmid_fetch got req %0b we %0b be %h addr %0h valid %0b want 1 0 f 110 1", out_ram_req, out_ram_we, out_ram_be, out_ram_addr, out_if_valid); end
        cyc(); idle_in();
    endtask

    // Randomized traffic: requesters hold until served, a RAM with random latency answers,
    // and a transaction-level model predicts grants, responses and final memory contents.
    task automatic test_random;
        logic [31:0] ram [16];
        logic [31:0] exp_mem [16];
        logic [3:0]  if_idx = 0, mem_idx = 0, m_be = 0, t_be = 0, p_be = 0, ridx;
        logic [31:0] m_wdata = 0, t_addr = 0, t_wdata = 0, p_if_addr = 0, p_mem_addr = 0, p_wdata = 0, exp_rd;
        bit if_act = 0, mem_act = 0, mem_wr = 0, mem_both = 0, gen, flush = 0, ack = 0;
        bit busy = 0, k_mem = 0, killed = 0, t_we = 0, exp_if_v, exp_mem_v;
        bit p_mem = 0, p_wr = 0, p_if = 0, p_flush = 0, p_ack = 0, if_done = 0, mem_done = 0;
        int lat = 0, n_if = 0, n_mem = 0, n_conf = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom;
            exp_mem[i] = ram[i];
        end
        do_reset();
        for (int c = 0; c < 700; c++) begin
            gen = c < 650;
            cyc();
            if (busy && p_ack) busy = 0;
            else if (!busy && (p_mem || (p_if && !p_flush))) begin
                busy = 1; k_mem = p_mem; killed = 0; lat = $urandom_range(0, 3);
                t_addr = p_mem ? p_mem_addr : p_if_addr;
                t_we = p_mem && p_wr; t_wdata = p_wdata; t_be = p_mem ? p_be : 4'hF;
                if (p_mem) n_mem++; else n_if++;
            end
            checks++; if (out_ram_req !== busy) begin errors++; $display("FAIL rnd_req cycle %0d got %0b want %0b", c, out_ram_req, busy); end
            if (busy) begin
                checks++; if ({out_ram_addr, out_ram_we, out_ram_be} !== {t_addr, t_we, t_be}) begin errors++; $display("FAIL rnd_bus cycle %0d got addr %0h we %0b be %h want %0h %0b %h", c, out_ram_addr, out_ram_we, out_ram_be, t_addr, t_we, t_be); end
                if (t_we) begin
                    checks++; if (out_ram_wdata !== t_wdata) begin errors++; $display("FAIL rnd_wdata cycle %0d got %0h want %0h", c, out_ram_wdata, t_wdata); end
                end
            end
            if (if_done) begin if_act = gen && $urandom_range(0, 3) != 0; if_idx = if_idx + 1; end
            if (p_flush) if_idx = if_idx + 4'($urandom_range(1, 15));
            if (!if_act && gen && $urandom_range(0, 1) == 1) begin if_act = 1; if_idx = 4'($urandom); end
            if (mem_done) mem_act = 0;
            if (!mem_act && gen && $urandom_range(0, 2) == 0) begin
                mem_act = 1; mem_wr = $urandom_range(0, 1) == 1; mem_both = mem_wr && $urandom_range(0, 3) == 0;
                mem_idx = 4'($urandom); m_wdata = $urandom; m_be = 4'($urandom_range(1, 15));
            end
            flush = gen && if_act && $urandom_range(0, 7) == 0;
            ack = busy && lat == 0;
            if (busy && !ack) lat--;
            if (!busy && mem_act && if_act) n_conf++;
            in_if_req = if_act; in_if_addr = 32'h100 | {26'd0, if_idx, 2'b00}; in_if_flush = flush;
            in_mem_read = mem_act && (!mem_wr || mem_both); in_mem_write = mem_act && mem_wr;
            in_mem_addr = 32'h2000 | {26'd0, mem_idx, 2'b00}; in_mem_wdata = m_wdata; in_mem_be = m_be;
            in_ram_ack = ack;
            ridx = out_ram_addr[5:2];
            in_ram_rdata = ack ? ram[ridx] : $urandom;
            smp();
            exp_if_v = ack && !k_mem && !killed && !flush;
            exp_mem_v = ack && k_mem;
            checks++; if ({out_if_valid, out_mem_valid} !== {exp_if_v, exp_mem_v}) begin errors++; $display("FAIL rnd_valid cycle %0d got if %0b mem %0b want %0b %0b", c, out_if_valid, out_mem_valid, exp_if_v, exp_mem_v); end
            exp_rd = exp_if_v ? exp_mem[if_idx] : 32'd0;
            checks++; if (out_if_rdata !== exp_rd) begin errors++; $display("FAIL rnd_if_rdata cycle %0d got %0h want %0h", c, out_if_rdata, exp_rd); end
            exp_rd = (exp_mem_v && !mem_wr) ? exp_mem[mem_idx] : 32'd0;
            checks++; if (out_mem_rdata !== exp_rd) begin errors++; $display("FAIL rnd_mem_rdata cycle %0d got %0h want %0h", c, out_mem_rdata, exp_rd); end
            checks++; if ({out_if_stall, out_mem_stall} !== {if_act && !exp_if_v, mem_act && !exp_mem_v}) begin errors++; $display("FAIL rnd_stall cycle %0d got %b want %b", c, {out_if_stall, out_mem_stall}, {if_act && !exp_if_v, mem_act && !exp_mem_v}); end
            if (exp_mem_v && mem_wr)
                for (int b = 0; b < 4; b++) if (m_be[b]) exp_mem[mem_idx][b*8 +: 8] = m_wdata[b*8 +: 8];
            if (ack && out_ram_we)
                for (int b = 0; b < 4; b++) if (out_ram_be[b]) ram[ridx][b*8 +: 8] = out_ram_wdata[b*8 +: 8];
            if (busy && !k_mem && flush) killed = 1;
            p_mem = mem_act; p_wr = mem_wr; p_mem_addr = in_mem_addr; p_wdata = m_wdata; p_be = m_be;
            p_if = if_act; p_if_addr = in_if_addr; p_flush = flush; p_ack = ack;
            if_done = exp_if_v; mem_done = exp_mem_v;
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (ram[i] !== exp_mem[i]) begin errors++; $display("FAIL rnd_mem word %0d got %0h want %0h", i, ram[i], exp_mem[i]); end
        end
        cyc(); idle_in(); cyc();
`ifdef MEM_ARBITER_PERF_EN
        checks++; if ({out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts} !== {32'(n_if), 32'(n_mem), 32'(n_conf)}) begin errors++; $display("FAIL rnd_perf got %0d %0d %0d want %0d %0d %0d", out_perf_if_grants, out_perf_mem_grants, out_perf_conflicts, n_if, n_mem, n_conf); end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fetch();
        test_collision();
        test_store();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
